uart_tx_serializer_v2: RTL and testbench
========================================

// Module: uart_tx_serializer_v2
// PURPOSE
// Parametrised UART TX data serializer, next generation of the fixed 8-bit shifter.
// - Accepts a parallel word via valid/ready handshake.
// - Frame length (1..WIDTH) and bit order (LSB/MSB first) are selectable per word.
// - Shifts one bit per baud tick while enabled by the TX FSM; supports pause and abort.
// - Outputs word parity for the parity stage.
// Sits between the TX front-end (data/valid) and the TX FSM/output mux.
// PARAMETERS
// WIDTH  8                 max data bits per frame (>=2)
// LEN_W  $clog2(WIDTH+1)   width of Data_Len and internal bit counter
// PORTS
// CLK         in   1      clock
// RST         in   1      reset, asynchronous, active-low
// P_DATA      in   WIDTH  parallel data word
// Data_Valid  in   1      P_DATA valid; accepted when Load_Ready=1
// Load_Ready  out  1      1 = IDLE, next Data_Valid is captured
// Data_Len    in   LEN_W  bits to send; sampled at load; 0 or >WIDTH -> WIDTH
// MSB_First   in   1      sampled at load; 1 = send P_DATA[len-1] first
// Ser_En      in   1      shift enable from TX FSM (data phase)
// Bit_Tick    in   1      one-cycle baud strobe; bit advances only on Ser_En&Bit_Tick
// Abort       in   1      synchronous cancel of the current word
// Ser_Data    out  1      current serial bit (registered)
// Ser_Done    out  1      one-cycle pulse on the cycle the last bit's period ends
// Busy        out  1      word loaded, not yet done/aborted
// Parity      out  1      XOR of the len valid bits of the loaded word; held until next load
// BEHAVIOUR
// Reset: Ser_Data=0, Ser_Done=0, Busy=0, Parity=0, Load_Ready=1, counter=0, state IDLE.
// Two states: IDLE, SHIFT. Load_Ready = (state==IDLE), combinational from state.
// IDLE: Data_Valid=1 -> capture next edge: len=clamp(Data_Len).
// - Bits above len-1 are masked to 0.
// - Shift reg holds bits in transmission order (MSB_First: field reversed).
// - Ser_Data = first bit; Parity computed from the masked word; counter=0; Busy=1 -> SHIFT.
// - Ser_En/Bit_Tick are ignored in IDLE and in the load cycle.
// SHIFT: each Ser_En&Bit_Tick -> counter+1.
// - If counter+1 < len: shift right, Ser_Data = next bit.
// - If counter+1 == len: Ser_Done=1 for that cycle, -> IDLE, Busy=0, Ser_Data=0.
// - Ser_En=0 or Bit_Tick=0: hold shift reg, counter and Ser_Data (pause). No restart.
// Latency: first bit visible 1 cycle after the accepted Data_Valid.
// - Done pulse coincides with the len-th qualifying tick edge.
// Data_Valid while Busy: ignored (no capture, no side effects); the source must hold.
// Abort in SHIFT: -> IDLE next edge.
// - Busy=0, Ser_Done=0, Ser_Data=0, counter=0.
// - Abort wins over a simultaneous last tick; no Done pulse.
// Abort in IDLE: ignored; a simultaneous Data_Valid is still accepted.
// len=1: Done on the first qualifying tick. Counter never exceeds len-1; no wrap.
// Async RST mid-frame: immediate return to reset values; partial word discarded.
// STRUCTURE
// Shared package uart_pkg holds:
// - state encoding localparams (IDLE/SHIFT);
// - function clamp_len(len, WIDTH);
// - function bit_reverse(data, len);
// - function parity_of(data) (reduction XOR).
// Single flat module with no sub-module; the shift reg, counter and 2-state FSM are small.
// TESTING (WIDTH=8, Bit_Tick every cycle, Ser_En=1 unless stated)
// 1 Load 0xB1, len 8, LSB first -> Ser_Data 1,0,0,0,1,1,0,1; Done on 8th tick; Parity=0.
// 2 Load 0xB1, len 8, MSB first -> Ser_Data 1,0,1,1,0,0,0,1; Done on 8th tick; Parity=0.
// 3 Load 0xFF, Data_Len=5 -> five 1s, Done on 5th tick, Parity=1; Data_Len=0 -> 8 bits sent.
// 4 Bit_Tick every 16 clk; Ser_En low for 3 ticks mid-word -> each bit held 16 clk;
//   no advance while Ser_En=0; totals unchanged.
// 5 Abort after 3 bits (same cycle as a tick) -> Busy=0, no Done, Load_Ready=1;
//   load 0x0F next cycle -> accepted and sent fully.
// 6 Data_Valid with 0x55 while Busy -> ignored, original word completes;
//   RST low mid-word -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART TX types and helpers: state encoding,
// frame-length clamp, field bit reversal and word parity.
package uart_pkg;

  localparam int MAX_W = 32;

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = S_IDLE,
    SHIFT = S_SHIFT
  } state_t;

  function automatic int clamp_len(
    input int len,
    input int width
  );
    return (len == 0 || len > width) ? width : len;
  endfunction

  // Reverses bits [len-1:0]; bits above len-1 must be 0.
  function automatic logic [MAX_W-1:0] bit_reverse(
    input logic [MAX_W-1:0] data,
    input int               len
  );
    logic [MAX_W-1:0] r;
    r = {<<{data}};
    return r >> (MAX_W - len);
  endfunction

  function automatic logic parity_of(
    input logic [MAX_W-1:0] data
  );
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_v2.sv
// UART TX serializer: loads a word via valid/ready, shifts
// 1..WIDTH bits LSB/MSB first on Ser_En&Bit_Tick, reports parity.
// Ports: CLK, RST (async low), P_DATA/Data_Valid/Load_Ready,
// Data_Len, MSB_First, Ser_En, Bit_Tick, Abort,
// Ser_Data, Ser_Done, Busy, Parity.
module uart_tx_serializer_v2
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  output logic             Load_Ready,
  input  logic [LEN_W-1:0] Data_Len,
  input  logic             MSB_First,
  input  logic             Ser_En,
  input  logic             Bit_Tick,
  input  logic             Abort,
  output logic             Ser_Data,
  output logic             Ser_Done,
  output logic             Busy,
  output logic             Parity
);

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic             data_n, done_n;
  logic             busy_n, par_n;

  logic [MAX_W-1:0] w;
  int               l;

  assign Load_Ready = (state == IDLE);

  always_comb begin
    state_n = state;
    sh_n    = sh;
    len_n   = len_q;
    cnt_n   = cnt;
    data_n  = Ser_Data;
    done_n  = 1'b0;
    busy_n  = Busy;
    par_n   = Parity;

    l = clamp_len(int'(Data_Len), WIDTH);
    w = MAX_W'(P_DATA);
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= l) w[i] = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (Data_Valid) begin
          len_n   = LEN_W'(l);
          sh_n    = MSB_First ?
                    WIDTH'(bit_reverse(w, l)) :
                    WIDTH'(w);
          data_n  = sh_n[0];
          par_n   = parity_of(w);
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (Abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          data_n  = 1'b0;
          cnt_n   = '0;
        end else if (Ser_En && Bit_Tick) begin
          if (cnt + LEN_W'(1) == len_q) begin
            done_n  = 1'b1;
            state_n = IDLE;
            busy_n  = 1'b0;
            data_n  = 1'b0;
            cnt_n   = '0;
          end else begin
            cnt_n  = cnt + LEN_W'(1);
            sh_n   = sh >> 1;
            data_n = sh[1];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      sh       <= '0;
      len_q    <= '0;
      cnt      <= '0;
      Ser_Data <= 1'b0;
      Ser_Done <= 1'b0;
      Busy     <= 1'b0;
      Parity   <= 1'b0;
    end else begin
      state    <= state_n;
      sh       <= sh_n;
      len_q    <= len_n;
      cnt      <= cnt_n;
      Ser_Data <= data_n;
      Ser_Done <= done_n;
      Busy     <= busy_n;
      Parity   <= par_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer_v2.sv
// Scoreboard bench for uart_tx_serializer_v2: a driver pushes
// expected frames, a negedge monitor pops and compares.
module tb_uart_tx_serializer_v2;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Load_Ready;
  logic [3:0] Data_Len;
  logic       MSB_First;
  logic       Ser_En;
  logic       Bit_Tick;
  logic       Abort;
  logic       Ser_Data;
  logic       Ser_Done;
  logic       Busy;
  logic       Parity;

  uart_tx_serializer_v2 dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Load_Ready (Load_Ready),
    .Data_Len   (Data_Len),
    .MSB_First  (MSB_First),
    .Ser_En     (Ser_En),
    .Bit_Tick   (Bit_Tick),
    .Abort      (Abort),
    .Ser_Data   (Ser_Data),
    .Ser_Done   (Ser_Done),
    .Busy       (Busy),
    .Parity     (Parity)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] bits;
    int         len;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, req, $time);
    end
  endtask

  function automatic logic bit_at(logic [7:0] v, int i);
    logic [7:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Frame in transmission order, built straight from the rules.
  function automatic exp_t model(logic [7:0] d, int dl,
                                 bit msb);
    exp_t e;
    int   ones;
    int   idx;
    logic b;
    e.bits = '0;
    e.len  = (dl == 0 || dl > 8) ? 8 : dl;
    ones   = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < e.len) begin
        idx = msb ? (e.len - 1 - i) : i;
        b = bit_at(d, idx);
        e.bits[i] = b;
        ones += int'(b);
      end
    end
    e.par = (ones % 2) == 1;
    return e;
  endfunction

  // Per-cycle drive of tick, enable and abort.
  int tick_mode   = 0;
  bit en_mode     = 0;
  int abort_rate  = 0;
  bit force_abort = 0;
  int slow_cnt    = 0;

  always @(posedge CLK) begin
    #1;
    slow_cnt++;
    case (tick_mode)
      0:       Bit_Tick = 1'b1;
      1:       Bit_Tick = ($urandom % 2) == 0;
      default: Bit_Tick = (slow_cnt % 16) == 0;
    endcase
    Ser_En = en_mode ? (($urandom % 4) != 0) : 1'b1;
    Abort  = force_abort ||
             (abort_rate != 0 &&
              ($urandom % abort_rate) == 0);
    force_abort = 0;
  end

  // Monitor.
  exp_t cur;
  bit   active   = 0;
  bit   pend_done  = 0;
  bit   pend_abort = 0;
  int   idx      = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      active     = 0;
      pend_done  = 0;
      pend_abort = 0;
      exp_q.delete();
    end else begin
      if (pend_done) begin
        chk("done_pulse", 32'(Ser_Done), 1);
        chk("busy_after_done", 32'(Busy), 0);
        pend_done = 0;
      end else begin
        chk("no_done", 32'(Ser_Done), 0);
      end
      if (pend_abort) begin
        chk("busy_after_abort", 32'(Busy), 0);
        chk("ready_after_abort", 32'(Load_Ready), 1);
        pend_abort = 0;
      end
      if (!Busy)
        chk("idle_data", 32'(Ser_Data), 0);
      if (!active && Busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_load", 32'(Busy), 0);
        end else begin
          cur    = exp_q.pop_front();
          active = 1;
          idx    = 0;
        end
      end
      if (active) begin
        chk("busy", 32'(Busy), 1);
        chk("parity", 32'(Parity), 32'(cur.par));
        chk("ser_data", 32'(Ser_Data),
            32'(bit_at(cur.bits, idx)));
        if (Abort) begin
          active     = 0;
          pend_abort = 1;
        end else if (Ser_En && Bit_Tick) begin
          idx++;
          if (idx == cur.len) begin
            active    = 0;
            pend_done = 1;
          end
        end
      end
    end
  end

  task automatic send(logic [7:0] d, logic [3:0] dl,
                      bit msb, bit junk);
    int n = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (Load_Ready) begin
        P_DATA     = d;
        Data_Len   = dl;
        MSB_First  = msb;
        Data_Valid = 1'b1;
        exp_q.push_back(model(d, int'(dl), msb));
        break;
      end
      Data_Valid = junk && (($urandom % 3) == 0);
      P_DATA     = 8'h55;
      Data_Len   = 4'($urandom);
      MSB_First  = 1'($urandom);
      n++;
      if (n > 3000) begin
        chk("load_timeout", 32'(Load_Ready), 1);
        return;
      end
    end
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 || active || Busy) begin
      @(negedge CLK);
      n++;
      if (n > 5000) begin
        chk("idle_timeout", 32'(Busy), 0);
        return;
      end
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_ser_data"}, 32'(Ser_Data), 0);
    chk({tag, "_ser_done"}, 32'(Ser_Done), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_parity"}, 32'(Parity), 0);
    chk({tag, "_load_ready"}, 32'(Load_Ready), 1);
  endtask

  initial begin
    RST        = 1'b1;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    Data_Len   = '0;
    MSB_First  = 1'b0;
    Ser_En     = 1'b1;
    Bit_Tick   = 1'b1;
    Abort      = 1'b0;
    #2 RST = 1'b0;
    #1 chk_reset_vals("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    send(8'hB1, 4'd8, 1'b0, 1'b0);
    send(8'hB1, 4'd8, 1'b1, 1'b0);
    send(8'hFF, 4'd5, 1'b0, 1'b0);
    send(8'hFF, 4'd0, 1'b0, 1'b0);
    send(8'h96, 4'd1, 1'b1, 1'b0);
    send(8'h3C, 4'd12, 1'b1, 1'b0);
    wait_idle();

    tick_mode = 2;
    en_mode   = 1;
    for (int i = 0; i < 3; i++)
      send(8'($urandom), 4'($urandom), 1'($urandom), 1'b1);
    wait_idle();

    tick_mode = 0;
    en_mode   = 0;
    send(8'hB1, 4'd8, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    force_abort = 1;
    send(8'h0F, 4'd8, 1'b0, 1'b0);
    wait_idle();

    tick_mode  = 1;
    en_mode    = 1;
    abort_rate = 25;
    for (int i = 0; i < 60; i++)
      send(8'($urandom), 4'($urandom), 1'($urandom), 1'b1);
    abort_rate = 0;
    wait_idle();

    tick_mode = 2;
    en_mode   = 0;
    send(8'hA7, 4'd8, 1'b0, 1'b0);
    repeat (20) @(posedge CLK);
    chk("busy_before_reset", 32'(Busy), 1);
    chk("parity_before_reset", 32'(Parity), 1);
    #3 RST = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;

    tick_mode = 0;
    send(8'h3C, 4'd3, 1'b1, 1'b0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
